region_write_arbiter: RTL and testbench
=======================================

// Module: region_write_arbiter
// PURPOSE
//  Shares the single write channel of a replicated fifo/bram region among NUM_REQ producers.
//  Arbitration is round-robin with burst lock: a granted producer owns the channel until it
//  sends a beat flagged last. FIFO-targeted beats are back-pressured with the region's almostfull.
//  All region-side outputs are registered. Sits between producer pipelines and the region write port.
// PARAMETERS
//  WIDTH       512  data width of one beat
//  LOG2_DEPTH  9    region address width (bram depth = 2**LOG2_DEPTH)
//  NUM_REQ     4    number of producers, 2..16
// PORTS
//  clk           in   1                 clock
//  reset         in   1                 asynchronous, active-low reset
//  req_valid     in   NUM_REQ           producer i presents a beat
//  req_last      in   NUM_REQ           beat is last of producer i's burst
//  req_fifobram  in   NUM_REQ*2         per-producer target: [0]=bram, [1]=fifo (both allowed)
//  req_waddr     in   NUM_REQ*LOG2_DEPTH  per-producer bram address
//  req_wdata     in   NUM_REQ*WIDTH     per-producer data
//  req_ready     out  NUM_REQ           beat of producer i accepted when valid&ready
//  wr_we         out  1                 region write enable
//  wr_wfifobram  out  2                 region target select
//  wr_waddr      out  LOG2_DEPTH        region bram address
//  wr_wdata      out  WIDTH             region data
//  wr_almostfull in   1                 region fifo almostfull
//  busy          out  1                 a burst is locked
//  owner         out  $clog2(NUM_REQ)   current/last granted producer
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rr_ptr=0, owner=0, busy=0, wr_we=0, wr_wfifobram=0,
//   wr_waddr=0, wr_wdata=0. All req_ready=0 while in reset.
//  FSM: IDLE, LOCK.
//   IDLE: req_ready=0. If any req_valid, pick first valid index searching rr_ptr, rr_ptr+1, ...
//    (mod NUM_REQ); register owner=that index, go LOCK, busy=1. No valid -> stay IDLE.
//   LOCK: req_ready[owner] = !(req_fifobram[owner][1] && wr_almostfull); all others 0.
//    A beat is accepted when req_valid[owner] && req_ready[owner].
//    Accepted beat with req_last[owner]: go IDLE, rr_ptr=owner+1 (wraps to 0 at NUM_REQ), busy=0.
//    Requests from non-owners are ignored (held by producer) until owner releases.
//  Latency: accepted beat appears on wr_* exactly 1 cycle later. wr_we=1 iff a beat was accepted
//   last cycle and its fifobram!=2'b00; wr_wfifobram/waddr/wdata copy the accepted beat.
//   fifobram==2'b00 beats are accepted and dropped (wr_we=0). wr_we returns to 0 in any cycle with
//   no accepted beat; wr_waddr/wr_wdata hold last value.
//  Throughput: one beat/cycle inside a burst; exactly one IDLE cycle between bursts.
//  Backpressure: wr_almostfull sampled combinationally each cycle; only FIFO-targeted beats stall;
//   bram-only beats pass while almostfull. Region's almostfull margin covers the 1-cycle pipeline.
//  Simultaneous valid from several producers in IDLE: rotating priority above; no producer waits more
//   than NUM_REQ-1 bursts.
//  Owner drops req_valid mid-burst: lock held, no beats issued, no timeout.
//  Reset mid-burst: burst abandoned; already-registered beat is discarded (wr_we cleared).
//  Assertions (sim): wr_we never 1 with wr_wfifobram==0; at most one req_ready high; req_ready
//   never high in IDLE.
// TESTING
//  1 Single producer 1, 3-beat bram burst addr 5,6,7 data A,B,C (last on C) -> wr_we high 3 cycles,
//    waddr 5,6,7 one cycle after each accept; busy falls after C; rr_ptr=2.
//  2 All 4 valid, 1-beat bursts, from reset -> grant order 0,1,2,3,0; one idle cycle between grants.
//  3 Owner 2 fifo burst, assert wr_almostfull for 4 cycles mid-burst -> req_ready[2]=0 those
//    cycles, no wr_we, burst resumes without loss/duplication; a bram-only beat is not stalled.
//  4 fifobram=2'b11 beat -> wr_we=1, wr_wfifobram=2'b11; fifobram=2'b00 beat -> accepted, wr_we=0.
//  5 Producer 0 holds 8-beat burst while 1 requests -> req_ready[1]=0 all 8 beats; 1 granted right
//    after idle cycle following 0's last.
//  6 Assert reset during beat 2 of 4 -> all outputs 0 asynchronously; after release, IDLE,
//    rr_ptr=0, fresh arbitration starts at producer 0.

Source files
------------

// File: rtl/region_write_arbiter.sv
// rtl/region_write_arbiter.sv - round-robin, burst-locked arbiter for a fifo/bram region write port
//
// Purpose: shares one region write channel among NUM_REQ producers. A granted
// producer keeps the channel until it sends a beat flagged last. FIFO-targeted
// beats stall on wr_almostfull. All region-side outputs are registered (1-cycle latency).
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req_valid/last      per-producer beat valid / end-of-burst flag
//   req_fifobram        per-producer target, 2 bits each: [0]=bram, [1]=fifo
//   req_waddr/wdata     per-producer bram address / data, packed by producer index
//   req_ready           per-producer accept (beat taken when valid & ready)
//   wr_we/wfifobram/waddr/wdata  registered region write port
//   wr_almostfull       region fifo almost full
//   busy                a burst is locked
//   owner               current / last granted producer
module region_write_arbiter #(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 9,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*2-1:0]          req_fifobram,
  input  logic [NUM_REQ*LOG2_DEPTH-1:0] req_waddr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_we,
  output logic [1:0]                    wr_wfifobram,
  output logic [LOG2_DEPTH-1:0]         wr_waddr,
  output logic [WIDTH-1:0]              wr_wdata,
  input  logic                          wr_almostfull,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam logic [OW:0] NREQ = (OW+1)'(NUM_REQ);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_LOCK = 1'b1;

  logic                  state;
  logic [OW-1:0]         rr_ptr;
  logic [OW-1:0]         rr_next;

  logic                  own_valid;
  logic                  own_last;
  logic                  own_ready;
  logic [1:0]            own_fb;
  logic [LOG2_DEPTH-1:0] own_addr;
  logic [WIDTH-1:0]      own_data;
  logic                  accept;

  logic                  grant_found;
  logic [OW-1:0]         grant_idx;
  logic [OW:0]           cand;

  // Current owner's beat, muxed out of the packed request buses.
  assign own_valid = req_valid[owner];
  assign own_last  = req_last[owner];
  assign own_fb    = req_fifobram[int'(owner)*2 +: 2];
  assign own_addr  = req_waddr[int'(owner)*LOG2_DEPTH +: LOG2_DEPTH];
  assign own_data  = req_wdata[int'(owner)*WIDTH +: WIDTH];

  // Only beats that reach the fifo are held back by almostfull.
  assign own_ready = (state == STATE_LOCK) && !(own_fb[1] && wr_almostfull);
  assign accept    = own_ready && own_valid;
  assign busy      = (state == STATE_LOCK);

  assign rr_next = (owner == OW'(NUM_REQ-1)) ? '0 : owner + OW'(1);

  always_comb begin
    req_ready        = '0;
    req_ready[owner] = own_ready;
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  // (NUM_REQ need not be a power of two, hence the explicit wrap).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (OW+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= STATE_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      wr_we        <= 1'b0;
      wr_wfifobram <= 2'b00;
      wr_waddr     <= '0;
      wr_wdata     <= '0;
    end else begin
      // Target 2'b00 beats are consumed but never written.
      wr_we <= accept && (own_fb != 2'b00);
      if (accept) begin
        wr_wfifobram <= own_fb;
        wr_waddr     <= own_addr;
        wr_wdata     <= own_data;
      end
      case (state)
        STATE_IDLE: begin
          if (grant_found) begin
            owner <= grant_idx;
            state <= STATE_LOCK;
          end
        end
        default: begin
          if (accept && own_last) begin
            state  <= STATE_IDLE;
            rr_ptr <= rr_next;
          end
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_we_has_target: assert property (@(posedge clk) disable iff (!reset)
    !(wr_we && wr_wfifobram == 2'b00));
  a_one_ready: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(req_ready));
  a_idle_no_ready: assert property (@(posedge clk) disable iff (!reset)
    (state == STATE_IDLE) |-> (req_ready == '0));
`endif

endmodule

// File: tb/tb_region_write_arbiter.sv
// tb/tb_region_write_arbiter.sv - directed vector bench for region_write_arbiter
module tb_region_write_arbiter;

  localparam int W  = 32;
  localparam int LD = 9;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR*2-1:0]  req_fifobram = '0;
  logic [NR*LD-1:0] req_waddr = '0;
  logic [NR*W-1:0]  req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic             wr_we;
  logic [1:0]       wr_wfifobram;
  logic [LD-1:0]    wr_waddr;
  logic [W-1:0]     wr_wdata;
  logic             wr_almostfull = 1'b0;
  logic             busy;
  logic [1:0]       owner;

  region_write_arbiter #(.WIDTH(W), .LOG2_DEPTH(LD), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_fifobram(req_fifobram),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_ready(req_ready),
    .wr_we(wr_we), .wr_wfifobram(wr_wfifobram), .wr_waddr(wr_waddr), .wr_wdata(wr_wdata),
    .wr_almostfull(wr_almostfull), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic [1:0] fb;
    logic       af;
    logic [8:0] addr;
    logic [31:0] data;
    logic [3:0] e_ready;
    logic       e_we;
    logic       e_busy;
    logic [1:0] e_owner;
    logic [1:0] e_fb;
    logic [8:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(bit r, logic [3:0] v, logic [3:0] l, logic [1:0] fb, logic af,
                              logic [8:0] a, logic [31:0] d, logic [3:0] er, logic ewe,
                              logic eb, logic [1:0] eo, logic [1:0] efb, logic [8:0] ea,
                              logic [31:0] ed);
    vec_t x;
    x.rst = r; x.valid = v; x.last = l; x.fb = fb; x.af = af; x.addr = a; x.data = d;
    x.e_ready = er; x.e_we = ewe; x.e_busy = eb; x.e_owner = eo;
    x.e_fb = efb; x.e_addr = ea; x.e_data = ed;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every producer sees the same address; data carries the producer index in its top nibble.
  task automatic drive(logic [3:0] v, logic [3:0] l, logic [1:0] fb, logic af,
                       logic [8:0] a, logic [31:0] d);
    req_valid = v;
    req_last = l;
    wr_almostfull = af;
    for (int i = 0; i < NR; i++) begin
      req_fifobram[i*2 +: 2] = fb;
      req_waddr[i*LD +: LD] = a;
      req_wdata[i*W +: W] = {4'(i), d[27:0]};
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'b1111, 4'b0000, 2'b01, 1'b0, 9'h1ff, 32'hffff_ffff);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_state", 64'({wr_we, busy, owner, wr_wfifobram}), 64'h0);
    chk("rst_addr_data", 64'({wr_waddr, wr_wdata}), 64'h0);
    drive(4'b0000, 4'b0000, 2'b00, 1'b0, 9'h0, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    // Test 1: producer 1, bram burst 5,6,7; then rr_ptr=2 shows as next grant.
    vq.push_back(mk(1, 4'b0010, 4'b0000, 2'b01, 0, 9'd5, 32'hA, 4'b0000, 0, 1, 2'd1, 0, 0, 0));
    vq.push_back(mk(0, 4'b0010, 4'b0000, 2'b01, 0, 9'd5, 32'hA, 4'b0010, 1, 1, 2'd1, 2'b01, 9'd5, 32'h1000_000A));
    vq.push_back(mk(0, 4'b0010, 4'b0000, 2'b01, 0, 9'd6, 32'hB, 4'b0010, 1, 1, 2'd1, 2'b01, 9'd6, 32'h1000_000B));
    vq.push_back(mk(0, 4'b0010, 4'b0010, 2'b01, 0, 9'd7, 32'hC, 4'b0010, 1, 0, 2'd1, 2'b01, 9'd7, 32'h1000_000C));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 2'b01, 0, 9'd0, 32'h0, 4'b0000, 0, 0, 2'd1, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h10, 32'h55, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h10, 32'h55, 4'b0100, 1, 0, 2'd2, 2'b01, 9'h10, 32'h2000_0055));
    // Test 2: all valid, single-beat bursts, grant order 0,1,2,3,0.
    vq.push_back(mk(1, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0000, 0, 1, 2'd0, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0001, 1, 0, 2'd0, 2'b01, 9'h20, 32'h0000_0001));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0000, 0, 1, 2'd1, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0010, 1, 0, 2'd1, 2'b01, 9'h20, 32'h1000_0001));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0100, 1, 0, 2'd2, 2'b01, 9'h20, 32'h2000_0001));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0000, 0, 1, 2'd3, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b1000, 1, 0, 2'd3, 2'b01, 9'h20, 32'h3000_0001));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0000, 0, 1, 2'd0, 0, 0, 0));
    vq.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 9'h20, 32'h1, 4'b0001, 1, 0, 2'd0, 2'b01, 9'h20, 32'h0000_0001));
    // Test 3: producer 2 fifo burst with almostfull for 4 cycles; bram-only beat passes.
    vq.push_back(mk(1, 4'b0100, 4'b0000, 2'b10, 0, 9'd1, 32'h11, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b10, 0, 9'd1, 32'h11, 4'b0100, 1, 1, 2'd2, 2'b10, 9'd1, 32'h2000_0011));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b10, 1, 9'd2, 32'h22, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b10, 1, 9'd2, 32'h22, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b10, 1, 9'd2, 32'h22, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b10, 1, 9'd2, 32'h22, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b10, 0, 9'd2, 32'h22, 4'b0100, 1, 1, 2'd2, 2'b10, 9'd2, 32'h2000_0022));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 2'b01, 1, 9'd3, 32'h33, 4'b0100, 1, 1, 2'd2, 2'b01, 9'd3, 32'h2000_0033));
    vq.push_back(mk(0, 4'b0100, 4'b0100, 2'b10, 1, 9'd4, 32'h44, 4'b0000, 0, 1, 2'd2, 0, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0100, 2'b10, 0, 9'd4, 32'h44, 4'b0100, 1, 0, 2'd2, 2'b10, 9'd4, 32'h2000_0044));
    // Test 4: fifobram 11 is written, 00 is accepted and dropped (even with almostfull).
    vq.push_back(mk(1, 4'b0001, 4'b0000, 2'b11, 0, 9'd9, 32'h99, 4'b0000, 0, 1, 2'd0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0001, 4'b0000, 2'b11, 0, 9'd9, 32'h99, 4'b0001, 1, 1, 2'd0, 2'b11, 9'd9, 32'h0000_0099));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 2'b00, 1, 9'hA, 32'hAA, 4'b0001, 0, 0, 2'd0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 9'h0, 32'h0, 4'b0000, 0, 0, 2'd0, 0, 0, 0));
    // Test 5: producer 0 holds an 8-beat burst while producer 1 waits.
    vq.push_back(mk(1, 4'b0011, 4'b0010, 2'b01, 0, 9'h40, 32'h0, 4'b0000, 0, 1, 2'd0, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vq.push_back(mk(0, 4'b0011, (k == 8) ? 4'b0011 : 4'b0010, 2'b01, 0, 9'(9'h40 + k), 32'(k),
                      4'b0001, 1, (k != 8), 2'd0, 2'b01, 9'(9'h40 + k), 32'(k)));
    vq.push_back(mk(0, 4'b0010, 4'b0010, 2'b01, 0, 9'h50, 32'h5, 4'b0000, 0, 1, 2'd1, 0, 0, 0));
    vq.push_back(mk(0, 4'b0010, 4'b0010, 2'b01, 0, 9'h50, 32'h5, 4'b0010, 1, 0, 2'd1, 2'b01, 9'h50, 32'h1000_0005));

    #1;
    foreach (vq[n]) begin
      if (vq[n].rst) do_reset();
      drive(vq[n].valid, vq[n].last, vq[n].fb, vq[n].af, vq[n].addr, vq[n].data);
      #1;
      chk($sformatf("v%0d_ready", n), 64'(req_ready), 64'(vq[n].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we_busy_owner", n), 64'({wr_we, busy, owner}),
          64'({vq[n].e_we, vq[n].e_busy, vq[n].e_owner}));
      if (vq[n].e_we)
        chk($sformatf("v%0d_beat", n), 64'({wr_wfifobram, wr_waddr, wr_wdata}),
            64'({vq[n].e_fb, vq[n].e_addr, vq[n].e_data}));
    end

    // Test 6: asynchronous reset during beat 2 of a 4-beat burst from producer 3.
    do_reset();
    drive(4'b1000, 4'b0000, 2'b01, 1'b0, 9'h77, 32'h7);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_beat1_we", 64'({wr_we, busy, owner}), 64'({1'b1, 1'b1, 2'd3}));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_ready", 64'(req_ready), 64'h0);
    chk("t6_async_state", 64'({wr_we, busy, owner, wr_wfifobram}), 64'h0);
    chk("t6_async_addr_data", 64'({wr_waddr, wr_wdata}), 64'h0);
    drive(4'b1001, 4'b1001, 2'b01, 1'b0, 9'h33, 32'h3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t6_idle_after_rst", 64'({wr_we, busy}), 64'h0);
    @(posedge clk);
    #1;
    chk("t6_fresh_grant", 64'({wr_we, busy, owner}), 64'({1'b0, 1'b1, 2'd0}));
    chk("t6_fresh_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("t6_fresh_beat", 64'({wr_we, wr_waddr, wr_wdata}), 64'({1'b1, 9'h33, 32'h0000_0003}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
